// File: rtl/mem_access_sequencer.sv
// Load/store sequencer for ld, ldi and st: computes base + offset,
// drives a fixed-latency RAM port and returns a valid/ready response.
module mem_access_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int OFF_W  = 19,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_base,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  generate
    if (RD_LAT < 1) begin : g_bad_lat
      $error("mem_access_sequencer: RD_LAT must be at least 1");
    end
  endgenerate

  localparam int CW = $clog2(RD_LAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [2:0]        state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ea_q;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [CW-1:0]     cnt;

  logic [DATA_W-1:0] ea_next;
  logic              addr_err;
  logic              is_bad;
  logic              is_ldi;
  logic              is_ld;
  logic              is_st;

  // Signed cast sign-extends the offset; the sum wraps naturally.
  assign ea_next  = req_base + DATA_W'($signed(req_offset));
  assign addr_err = |ea_q[DATA_W-1:ADDR_W];

  assign is_ldi = (op_q == OP_LDI);
  assign is_bad = (op_q == OP_RSV) | (addr_err & ~is_ldi);
  assign is_ld  = (op_q == OP_LD) & ~addr_err;
  assign is_st  = (op_q == OP_ST) & ~addr_err;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign mem_read  = (state == S_READ);
  assign mem_write = (state == S_WRITE);
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= S_IDLE;
      op_q     <= '0;
      wdata_q  <= '0;
      ea_q     <= '0;
      mar      <= '0;
      mdr      <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            wdata_q <= req_wdata;
            ea_q    <= ea_next;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          mar     <= ea_q[ADDR_W-1:0];
          mdr     <= wdata_q;
          rsp_err <= 1'b0;
          unique case (1'b1)
            is_bad: begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
              state    <= S_RESP;
            end
            is_ldi: begin
              rsp_data <= ea_q;
              state    <= S_RESP;
            end
            is_ld:   state <= S_READ;
            is_st:   state <= S_WRITE;
            default: state <= S_RESP;
          endcase
        end
        S_READ: begin
          cnt   <= CW'(RD_LAT);
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rsp_data <= mem_rdata;
            state    <= S_RESP;
          end
        end
        S_WRITE: begin
          rsp_data <= mdr;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: two instances (RD_LAT 1 and 3)
// sharing one RAM model, checked with immediate assertions.
module tb_mem_access_sequencer;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_base;
  logic [18:0] req_offset;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [8:0]  mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        v3;
  logic        rr3;
  logic        rv3;
  logic        r3;
  logic [31:0] rd3;
  logic        re3;
  logic [8:0]  ma3;
  logic        mr3;
  logic        mw3;
  logic [31:0] mwd3;
  logic [31:0] mrd3;
  logic        busy3;

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_sequencer #(.RD_LAT(1)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_access_sequencer #(.RD_LAT(3)) dut3 (
    .clock(clock), .clear(clear),
    .req_valid(v3), .req_ready(rr3),
    .req_op(req_op), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_ready(r3),
    .rsp_data(rd3), .rsp_err(re3),
    .mem_addr(ma3), .mem_read(mr3),
    .mem_write(mw3), .mem_wdata(mwd3),
    .mem_rdata(mrd3), .busy(busy3)
  );

  // RAM model: dut writes, both read; idle read ports return a marker.
  logic [31:0] mem [0:511];
  logic [31:0] p3 [0:2];

  always @(posedge clock) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_read ? mem[mem_addr] : 32'hDEADBEEF;
    p3[0] <= mr3 ? mem[ma3] : 32'hDEADBEEF;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign mrd3 = p3[2];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] base,
                       input logic [18:0] off, input logic [31:0] wd);
    req_op     = op;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
  endtask

  initial begin
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_base   = '0;
    req_offset = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    v3         = 1'b0;
    r3         = 1'b1;
    clear      = 1'b0;
    #1 clear = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_req_ready3", rr3, 1);
    step();
    step();
    clear = 1'b0;

    // ST base 0 + 5
    issue(2'b10, 32'h0, 19'd5, 32'h12345678);
    chk("st_busy", busy, 1);
    chk("st_req_ready", req_ready, 0);
    chk("st_calc_valid", rsp_valid, 0);
    step();
    chk("st_write", {mem_read, mem_write}, 2'b01);
    chk("st_addr", mem_addr, 5);
    chk("st_wdata", mem_wdata, 32'h12345678);
    chk("st_wr_valid", rsp_valid, 0);
    step();
    chk("st_valid", rsp_valid, 1);
    chk("st_data", rsp_data, 32'h12345678);
    chk("st_err", rsp_err, 0);
    chk("st_write_off", mem_write, 0);
    step();
    chk("st_done_valid", rsp_valid, 0);
    chk("st_done_ready", req_ready, 1);

    // LD base 3 + 2, RD_LAT 1
    issue(2'b00, 32'h3, 19'd2, 32'h0);
    step();
    chk("ld_read", {mem_read, mem_write}, 2'b10);
    chk("ld_addr", mem_addr, 5);
    step();
    chk("ld_read_off", mem_read, 0);
    chk("ld_wait_valid", rsp_valid, 0);
    step();
    chk("ld_valid", rsp_valid, 1);
    chk("ld_data", rsp_data, 32'h12345678);
    chk("ld_err", rsp_err, 0);
    step();
    chk("ld_done", rsp_valid, 0);

    // LD on the RD_LAT 3 instance
    v3 = 1'b1;
    step();
    v3 = 1'b0;
    step();
    chk("ld3_read", mr3, 1);
    chk("ld3_addr", ma3, 5);
    step();
    step();
    step();
    chk("ld3_early", rv3, 0);
    step();
    chk("ld3_valid", rv3, 1);
    chk("ld3_data", rd3, 32'h12345678);
    step();
    chk("ld3_done", rv3, 0);

    // LDI 0x10 + (-1)
    issue(2'b01, 32'h10, 19'h7FFFF, 32'h0);
    chk("ldi_calc_strobes", {mem_read, mem_write}, 0);
    step();
    chk("ldi_valid", rsp_valid, 1);
    chk("ldi_data", rsp_data, 32'h0000000F);
    chk("ldi_err", rsp_err, 0);
    chk("ldi_strobes", {mem_read, mem_write}, 0);
    step();

    // LD out of range: EA 0x210
    issue(2'b00, 32'h1F0, 19'h20, 32'h0);
    step();
    chk("err_valid", rsp_valid, 1);
    chk("err_err", rsp_err, 1);
    chk("err_data", rsp_data, 0);
    chk("err_strobes", {mem_read, mem_write}, 0);
    chk("err_mar", mem_addr, 9'h010);
    step();

    // Reserved op
    issue(2'b11, 32'h0, 19'd5, 32'h0);
    step();
    chk("rsv_valid", rsp_valid, 1);
    chk("rsv_err", rsp_err, 1);
    chk("rsv_data", rsp_data, 0);
    step();

    // Backpressure with a pending second request
    rsp_ready = 1'b0;
    issue(2'b00, 32'h0, 19'd5, 32'h0);
    step();
    step();
    step();
    chk("bp_valid", rsp_valid, 1);
    chk("bp_data", rsp_data, 32'h12345678);
    req_op     = 2'b01;
    req_base   = 32'h100;
    req_offset = 19'd1;
    req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 32'h12345678);
      chk("bp_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_hs_valid", rsp_valid, 0);
    chk("bp_hs_busy", busy, 0);
    step();
    chk("bp_accept", busy, 1);
    req_valid = 1'b0;
    step();
    chk("bp2_valid", rsp_valid, 1);
    chk("bp2_data", rsp_data, 32'h00000101);
    step();

    // Clear during WAIT, then a clean LD
    issue(2'b10, 32'h0, 19'd7, 32'hCAFEF00D);
    step();
    step();
    step();
    issue(2'b00, 32'h0, 19'd7, 32'h0);
    step();
    step();
    chk("clr_in_wait", busy, 1);
    #1 clear = 1'b1;
    #1;
    chk("clr_req_ready", req_ready, 1);
    chk("clr_busy", busy, 0);
    chk("clr_rsp_valid", rsp_valid, 0);
    chk("clr_rsp_data", rsp_data, 0);
    chk("clr_mem_addr", mem_addr, 0);
    chk("clr_mem_wdata", mem_wdata, 0);
    step();
    clear = 1'b0;
    step();
    chk("clr_stale_valid", rsp_valid, 0);
    issue(2'b00, 32'h0, 19'd5, 32'h0);
    step();
    step();
    step();
    chk("post_clr_valid", rsp_valid, 1);
    chk("post_clr_data", rsp_data, 32'h12345678);
    chk("post_clr_err", rsp_err, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
